// File: rtl/ctrl_pkg.sv
// Shared definitions for the ctrl_seq sequencer: opcodes, FSM states,
// flag bit positions and instruction field layout.
package ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_CMP  = 4'b0011,
        OP_RSH  = 4'b0100,
        OP_LSH  = 4'b0101,
        OP_LDI  = 4'b0110,
        OP_JE   = 4'b1001,
        OP_JG   = 4'b1010,
        OP_JL   = 4'b1011,
        OP_HALT = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    localparam int CARRY = 0;
    localparam int OVF   = 1;
    localparam int NEG   = 2;
    localparam int ZERO  = 3;

    localparam int OPC_MSB = 11;
    localparam int OPC_LSB = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 6;
    localparam int RB_MSB  = 5;
    localparam int RB_LSB  = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    localparam int REG_W  = 4;
    localparam int NREGS  = 4;

    function automatic logic loads_flags(input opcode_e op);
        return (op == OP_ADD) || (op == OP_CMP) || (op == OP_JE) ||
               (op == OP_JG)  || (op == OP_JL);
    endfunction

    function automatic logic writes_alu_result(input opcode_e op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_RSH) || (op == OP_LSH);
    endfunction

    // Branch decisions look at the ALU flags produced this cycle.
    function automatic logic jump_taken(input opcode_e op, input logic [3:0] ef);
        case (op)
            OP_JE:   return ef[ZERO];
            OP_JG:   return !ef[ZERO] && !ef[NEG];
            OP_JL:   return ef[NEG];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// 4x4-bit register file: two combinational read ports, one clocked write
// port, asynchronous active-low clear.
module regfile
    import ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [1:0]       waddr_i,
    input  logic [REG_W-1:0] wdata_i,
    input  logic [1:0]       raddr_a_i,
    input  logic [1:0]       raddr_b_i,
    output logic [REG_W-1:0] rdata_a_o,
    output logic [REG_W-1:0] rdata_b_o
);

    logic [REG_W-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the pre-write contents, so ra==rb uses old operand values.
    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/ctrl_seq.sv
// Fetch/execute sequencer driving an external ALU from a 4-entry register
// file; one instruction per FETCH+EXEC pair, stops in HALT until reset.
module ctrl_seq
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [3:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [11:0] imem_rdata,
    output logic [3:0]  alu_opcode,
    output logic [3:0]  alu_op1,
    output logic [3:0]  alu_op2,
    input  logic [3:0]  alu_dout,
    input  logic [3:0]  alu_eflags,
    output logic        busy,
    output logic        halted,
    output logic [3:0]  flags,
    output logic [3:0]  pc
);

    state_e      state_q;
    logic [3:0]  pc_q;
    logic [11:0] ir_q;
    logic [3:0]  flags_q;
    logic        imem_req_q;
    logic        busy_q;
    logic        halted_q;

    opcode_e     op;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic [3:0]  imm;
    logic        in_exec;
    logic        rf_we;
    logic [3:0]  rf_wdata;
    logic [3:0]  rd_a;
    logic [3:0]  rd_b;

    assign op      = opcode_e'(ir_q[OPC_MSB:OPC_LSB]);
    assign ra      = ir_q[RA_MSB:RA_LSB];
    assign rb      = ir_q[RB_MSB:RB_LSB];
    assign imm     = ir_q[IMM_MSB:IMM_LSB];
    assign in_exec = (state_q == S_EXEC);

    assign rf_we    = in_exec && (writes_alu_result(op) || (op == OP_LDI));
    assign rf_wdata = (op == OP_LDI) ? imm : alu_dout;

    regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (rf_we),
        .waddr_i   (ra),
        .wdata_i   (rf_wdata),
        .raddr_a_i (ra),
        .raddr_b_i (rb),
        .rdata_a_o (rd_a),
        .rdata_b_o (rd_b)
    );

    // ALU inputs are held at zero except during the single EXEC cycle.
    assign alu_opcode = in_exec ? ir_q[OPC_MSB:OPC_LSB] : 4'd0;
    assign alu_op1    = in_exec ? rd_a : 4'd0;
    assign alu_op2    = in_exec ? rd_b : 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            flags_q    <= '0;
            imem_req_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_q       <= '0;
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        state_q    <= S_EXEC;
                        imem_req_q <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (loads_flags(op)) begin
                        flags_q <= alu_eflags;
                    end
                    if (op == OP_HALT) begin
                        state_q  <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q       <= jump_taken(op, alu_eflags) ? imm : pc_q + 4'd1;
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign flags     = flags_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq with a behavioural ALU and hand-computed
// expectations for each instruction.
module tb_ctrl_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic        imem_ack;
    logic [11:0] imem_rdata;
    logic [3:0]  alu_opcode;
    logic [3:0]  alu_op1;
    logic [3:0]  alu_op2;
    logic [3:0]  alu_dout;
    logic [3:0]  alu_eflags;
    logic        busy;
    logic        halted;
    logic [3:0]  flags;
    logic [3:0]  pc;

    int          n_chk;
    int          n_pass;
    logic [3:0]  cur_pc;

    ctrl_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .alu_opcode (alu_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_dout   (alu_dout),
        .alu_eflags (alu_eflags),
        .busy       (busy),
        .halted     (halted),
        .flags      (flags),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; flags are {zero, neg, ovf, carry}, compares use borrow.
    logic [4:0] alu_s;
    logic [7:0] alu_p;
    always_comb begin
        alu_dout   = 4'hF;
        alu_eflags = 4'b1110;
        alu_s      = '0;
        alu_p      = '0;
        case (alu_opcode)
            4'b0001: begin
                alu_s      = {1'b0, alu_op1} + {1'b0, alu_op2};
                alu_dout   = alu_s[3:0];
                alu_eflags = {alu_s[3:0] == 4'd0, alu_s[3],
                              (alu_op1[3] == alu_op2[3]) && (alu_s[3] != alu_op1[3]), alu_s[4]};
            end
            4'b0011, 4'b1001, 4'b1010, 4'b1011: begin
                alu_s      = {1'b0, alu_op1} - {1'b0, alu_op2};
                alu_dout   = alu_s[3:0];
                alu_eflags = {alu_s[3:0] == 4'd0, alu_s[3],
                              (alu_op1[3] != alu_op2[3]) && (alu_s[3] != alu_op1[3]),
                              alu_op1 < alu_op2};
            end
            4'b0010: begin
                alu_p      = alu_op1 * alu_op2;
                alu_dout   = alu_p[3:0];
                alu_eflags = {alu_p[3:0] == 4'd0, alu_p[3], 2'b00};
            end
            4'b0100: begin
                alu_dout   = alu_op1 >> 1;
                alu_eflags = 4'b0000;
            end
            4'b0101: begin
                alu_dout   = alu_op1 << 1;
                alu_eflags = 4'b0000;
            end
            default: begin
                alu_dout   = 4'hF;
                alu_eflags = 4'b1110;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cur_pc = 4'd0;
    endtask

    // Serves one fetch after 'waits' stall cycles, then checks EXEC and commit.
    task automatic do_instr(input logic [11:0] ins, input int waits,
                            input logic [3:0] e_op1, input logic [3:0] e_op2,
                            input logic [3:0] e_pc, input logic [3:0] e_flags);
        int         t;
        int         reqcyc;
        logic [3:0] opc;
        t      = 0;
        reqcyc = 0;
        opc    = ins[11:8];
        while (imem_req !== 1'b1 && t < 32) begin
            @(negedge clk);
            t++;
        end
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        if (imem_req === 1'b1) begin
            chk("fetch_addr", {28'd0, imem_addr}, {28'd0, cur_pc});
            for (int i = 0; i < waits; i++) begin
                if (imem_req === 1'b1) reqcyc++;
                @(negedge clk);
            end
            if (imem_req === 1'b1) reqcyc++;
            imem_ack   = 1'b1;
            imem_rdata = ins;
            @(negedge clk);
            imem_ack   = 1'b0;
            imem_rdata = 12'h000;
            chk("req_cycles", reqcyc, waits + 1);
            chk("exec_req_low", {31'd0, imem_req}, 32'd0);
            chk("exec_opcode", {28'd0, alu_opcode}, {28'd0, opc});
            chk("exec_op1", {28'd0, alu_op1}, {28'd0, e_op1});
            chk("exec_op2", {28'd0, alu_op2}, {28'd0, e_op2});
            chk("exec_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
            chk("commit_pc", {28'd0, pc}, {28'd0, e_pc});
            chk("commit_flags", {28'd0, flags}, {28'd0, e_flags});
            chk("idle_alu_opc", {28'd0, alu_opcode}, 32'd0);
            chk("idle_alu_op1", {28'd0, alu_op1}, 32'd0);
            cur_pc = e_pc;
        end
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        cur_pc     = 4'd0;
        rst_n      = 1'b0;
        start      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 12'h000;
        #23;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", {28'd0, pc}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", {31'd0, imem_req}, 32'd0);

        pulse_start();
        //        instr   waits op1    op2    pc     flags
        do_instr(12'h645, 3, 4'd0,  4'd0,  4'd1,  4'h0);  // LDI R1,5
        do_instr(12'h647, 0, 4'd5,  4'd0,  4'd2,  4'h0);  // LDI R1,7
        do_instr(12'h689, 1, 4'd0,  4'd0,  4'd3,  4'h0);  // LDI R2,9
        do_instr(12'h160, 2, 4'd7,  4'd9,  4'd4,  4'h9);  // ADD R1,R2
        do_instr(12'h1A0, 0, 4'd9,  4'd9,  4'd5,  4'h3);  // ADD R2,R2
        do_instr(12'h060, 0, 4'd0,  4'd2,  4'd6,  4'h3);  // NOP
        do_instr(12'h603, 1, 4'd0,  4'd0,  4'd7,  4'h3);  // LDI R0,3
        do_instr(12'h643, 0, 4'd0,  4'd3,  4'd8,  4'h3);  // LDI R1,3
        do_instr(12'h91C, 0, 4'd3,  4'd3,  4'd12, 4'h8);  // JE taken
        do_instr(12'h644, 0, 4'd3,  4'd3,  4'd13, 4'h8);  // LDI R1,4
        do_instr(12'h912, 2, 4'd3,  4'd4,  4'd14, 4'h5);  // JE not taken
        do_instr(12'hB1F, 0, 4'd3,  4'd4,  4'd15, 4'h5);  // JL taken
        do_instr(12'h000, 0, 4'd3,  4'd3,  4'd0,  4'h5);  // NOP wraps pc
        do_instr(12'hA43, 1, 4'd4,  4'd3,  4'd3,  4'h0);  // JG taken
        do_instr(12'h310, 0, 4'd3,  4'd4,  4'd4,  4'h5);  // CMP R0,R1
        do_instr(12'h210, 0, 4'd3,  4'd4,  4'd5,  4'h5);  // MUL keeps flags
        do_instr(12'h400, 0, 4'd12, 4'd12, 4'd6,  4'h5);  // RSH R0
        do_instr(12'h700, 0, 4'd6,  4'd6,  4'd7,  4'h5);  // undefined
        do_instr(12'h000, 0, 4'd6,  4'd6,  4'd8,  4'h5);  // NOP
        do_instr(12'hF00, 0, 4'd6,  4'd6,  4'd8,  4'h5);  // HALT

        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_busy", {31'd0, busy}, 32'd0);
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("halt_hold", {31'd0, halted}, 32'd1);
        chk("halt_req2", {31'd0, imem_req}, 32'd0);
        chk("halt_pc", {28'd0, pc}, 32'd8);

        // Reset out of HALT, run one instruction, then reset mid-fetch.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        pulse_start();
        do_instr(12'h080, 0, 4'd0, 4'd0, 4'd1, 4'h0);
        chk("mf_req_before", {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 12'h6FF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mf_req_async", {31'd0, imem_req}, 32'd0);
        chk("mf_busy", {31'd0, busy}, 32'd0);
        chk("mf_pc", {28'd0, pc}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        imem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("mf_idle_req", {31'd0, imem_req}, 32'd0);
        chk("mf_idle_busy", {31'd0, busy}, 32'd0);
        pulse_start();
        do_instr(12'h6C1, 0, 4'd0, 4'd0, 4'd1, 4'h0);  // LDI R3,1

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, one-cycle pulse that begins execution from IDLE.
REQ-004 SHALL have port imem_req, output, 1, instruction fetch request.
REQ-005 SHALL have port imem_addr, output, 4, fetch address (the PC).
REQ-006 SHALL have port imem_ack, input, 1, fetch data valid this cycle.
REQ-007 SHALL have port imem_rdata, input, 12, instruction: [11:8] opcode, [7:6] ra, [5:4] rb, [3:0] imm/target.
REQ-008 SHALL have ports alu_opcode, alu_op1, alu_op2, output, 4 each, feeding the ALU.
REQ-009 SHALL have ports alu_dout, alu_eflags, input, 4 each, returned by the ALU (flags: [0] carry, [1] overflow, [2] neg, [3] zero).
REQ-010 SHALL have ports busy, halted, output, 1 each; flags, output, 4, architectural flags register; pc, output, 4.

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, EXEC, HALT.
REQ-012 IDLE: start=1 -> pc<=0, go FETCH; start ignored in every other state.
REQ-013 FETCH: imem_req=1, imem_addr=pc; hold until imem_ack=1, then latch imem_rdata into ir, go EXEC; no timeout.
REQ-014 EXEC: exactly one cycle; alu_opcode=ir[11:8], alu_op1=R[ra], alu_op2=R[rb]; results committed at the EXEC clock edge, next state FETCH (HALT for 1111).
REQ-015 Outside EXEC, alu_opcode, alu_op1 and alu_op2 SHALL be 0.
REQ-016 0001 add, 0010 mul, 0100 rsh, 0101 lsh: R[ra]<=alu_dout.
REQ-017 Flags register SHALL load alu_eflags only for 0001, 0011, 1001, 1010, 1011; all other opcodes leave it unchanged.
REQ-018 0110 LDI: R[ra]<=imm; the ALU result is ignored.
REQ-019 1001 je: taken if alu_eflags[3]=1; 1010 jg: taken if eflags[3]=0 and eflags[2]=0; 1011 jl: taken if eflags[2]=1; decision uses same-cycle alu_eflags, not the stored flags.
REQ-020 Taken jump: pc<=imm; otherwise pc<=pc+1 mod 16 (15 wraps to 0).
REQ-021 0000 and undefined opcodes (0111, 1000, 1100-1110): no register or flag write, pc+1.
REQ-022 1111 HALT: pc unchanged, go HALT; HALT is held until reset; halted=1 in HALT only.
REQ-023 busy=1 in FETCH and EXEC, 0 otherwise.
REQ-024 Register write to ra where ra==rb SHALL use pre-write operand values (read before write).

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, pc=0, ir=0, flags=0, R0-R3=0, imem_req=0, busy=0, halted=0, independent of clk.
REQ-026 Reset asserted mid-FETCH SHALL drop imem_req asynchronously and discard any pending ack.
REQ-027 First state after reset release SHALL be IDLE; start is required to resume.

Structure
REQ-028 Shared package ctrl_pkg SHALL hold the opcode enum (4-bit), FSM state enum, flag bit index constants (CARRY=0, OVF=1, NEG=2, ZERO=3) and the instruction field positions.
REQ-029 The 4x4-bit register file SHALL be a sub-module regfile (two async read ports, one sync write port, async active-low clear).

Verification
REQ-030 Reset then start, imem_ack after 3 waits on LDI R1,5 -> imem_req high 4 cycles, R1=5, pc=1.
REQ-031 R1=7, R2=9, ADD R1,R2 -> R1=0, flags[0]=1, flags[3]=1, pc+1.
REQ-032 R0=3, R1=3, je R0,R1,target 12 -> pc=12; same with R1=4 -> pc=pc+1; jl with R0=3,R1=4 -> taken.
REQ-033 NOP at pc=15 -> pc wraps to 0; MUL after CMP leaves flags unchanged.
REQ-034 HALT -> halted=1, busy=0, further start pulses ignored, pc frozen.
REQ-035 rst_n low mid-FETCH -> imem_req 0 the same cycle, all registers 0, state IDLE.
